darkfetch: RTL and testbench

DARKFETCH -- requirements
Module: darkfetch

---
 rtl/darkfetch_if.sv | 28 ++
 rtl/darkfetch.sv | 136 +++++++++++++
 tb/tb_darkfetch.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/darkfetch_if.sv
// Fetch-stage bundle: PC register link, instruction memory request/response,
// redirect from execute and the decode-side instruction stream.
interface darkfetch_if;
  logic [31:0] PC;
  logic        EN;
  logic [31:0] NXPC;
  logic        IREQ;
  logic [31:0] IADDR;
  logic        IACK;
  logic        IRVALID;
  logic [31:0] IDATA;
  logic        JMP;
  logic [31:0] JADDR;
  logic        IVALID;
  logic [31:0] INSTR;
  logic [31:0] IPC;
  logic        IREADY;

  modport master (
    input  PC, IACK, IRVALID, IDATA, JMP, JADDR, IREADY,
    output EN, NXPC, IREQ, IADDR, IVALID, INSTR, IPC
  );

  modport slave (
    output PC, IACK, IRVALID, IDATA, JMP, JADDR, IREADY,
    input  EN, NXPC, IREQ, IADDR, IVALID, INSTR, IPC
  );
endinterface

// File: rtl/darkfetch.sv
// Instruction fetch unit: one outstanding memory request at a time, a 2-entry
// instruction buffer toward decode, and redirect handling that drops stale data.
module darkfetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RES,
  darkfetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic        ivalid;

  logic [31:0] entry_instr [DEPTH];
  logic [31:0] entry_pc    [DEPTH];

  // Issue is gated by reset so nothing leaks out while RES is held low.
  assign bus.IREQ  = RES & (state_q == ST_IDLE) & (count_q < DEPTH_C) & ~bus.JMP;
  assign bus.IADDR = bus.PC;
  assign accept    = bus.IREQ & bus.IACK;

  assign bus.EN    = RES & (bus.JMP | accept);
  assign bus.NXPC  = bus.JMP ? bus.JADDR : (bus.PC + 32'd4);

  assign ivalid     = (count_q != 2'd0);
  assign bus.IVALID = ivalid;
  assign bus.INSTR  = entry_instr[rd_ptr_q];
  assign bus.IPC    = entry_pc[rd_ptr_q];

  // A redirect wins over both push and pop: the buffer empties on that edge.
  assign push = (state_q == ST_WAIT) & bus.IRVALID & ~bus.JMP;
  assign pop  = ivalid & bus.IREADY & ~bus.JMP;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_WAIT;
          pend_addr_d = bus.PC;
        end
      end
      ST_WAIT: begin
        if (bus.IRVALID)  state_d = ST_IDLE;
        else if (bus.JMP) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (bus.IRVALID) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.JMP) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q     <= ST_IDLE;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pend_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] instr_q, instr_d;
      logic [31:0] pc_q, pc_d;
      logic        we;

      assign we = push & (wr_ptr_q == 1'(gi));

      always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (we) begin
          instr_d = bus.IDATA;
          pc_d    = pend_addr_q;
        end
      end

      always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
          instr_q <= 32'd0;
          pc_q    <= 32'd0;
        end else begin
          instr_q <= instr_d;
          pc_q    <= pc_d;
        end
      end

      assign entry_instr[gi] = instr_q;
      assign entry_pc[gi]    = pc_q;
    end
  endgenerate

endmodule

// File: tb/tb_darkfetch.sv
// Directed bench for darkfetch: reset, basic fetch, buffer fill/drain,
// redirect in WAIT / IDLE, same-cycle push+pop, PC wrap and mid-fetch reset.
`timescale 1ns/1ps

module tb_darkfetch;

    logic CLK;
    logic RES;
    int   tests;
    int   fails;
    logic done;

    darkfetch_if bus ();

    darkfetch #(
        .RESET_PC (32'h0000_0040),
        .DEPTH    (2)
    ) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        done = 1'b0;
        #100000;
        if (!done) begin
            fails++;
            $error("FAIL timeout: directed sequence did not complete");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        RES         = 1'b0;
        bus.PC      = 32'h0;
        bus.IACK    = 1'b1;
        bus.IRVALID = 1'b0;
        bus.IDATA   = 32'h0;
        bus.JMP     = 1'b0;
        bus.JADDR   = 32'h0;
        bus.IREADY  = 1'b0;
        tick();
        tick();

        check("rst_ireq",   bus.IREQ,        1'b0);
        check("rst_en",     bus.EN,          1'b0);
        check("rst_ivalid", bus.IVALID,      1'b0);
        check("rst_state",  dut.state_q,     2'd0);
        check("rst_count",  dut.count_q,     2'd0);
        check("rst_pend",   dut.pend_addr_q, 32'h0000_0040);
        check("rst_instr",  bus.INSTR,       32'h0);
        $display("[TB] reset checked");

        RES = 1'b1;
        settle();
        check("f0_ireq",  bus.IREQ,  1'b1);
        check("f0_iaddr", bus.IADDR, 32'h0);
        check("f0_en",    bus.EN,    1'b1);
        check("f0_nxpc",  bus.NXPC,  32'h4);
        tick();
        bus.PC      = 32'h4;
        bus.IACK    = 1'b0;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'h0000_0013;
        settle();
        check("f0_wait_ireq", bus.IREQ,   1'b0);
        check("f0_wait_iv",   bus.IVALID, 1'b0);
        tick();
        bus.IRVALID = 1'b0;
        settle();
        check("f0_ivalid", bus.IVALID, 1'b1);
        check("f0_instr",  bus.INSTR,  32'h0000_0013);
        check("f0_ipc",    bus.IPC,    32'h0);
        $display("[TB] fetch pc=00000000 instr=00000013");

        check("f1_ireq",  bus.IREQ,  1'b1);
        check("f1_iaddr", bus.IADDR, 32'h4);
        bus.IACK = 1'b1;
        tick();
        bus.PC      = 32'h8;
        bus.IACK    = 1'b0;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'h1111_1111;
        tick();
        bus.IRVALID = 1'b0;
        bus.IACK    = 1'b1;
        settle();
        check("full_count", dut.count_q, 2'd2);
        check("full_ireq",  bus.IREQ,    1'b0);
        check("full_en",    bus.EN,      1'b0);
        check("full_ipc",   bus.IPC,     32'h0);
        bus.IACK   = 1'b0;
        bus.IREADY = 1'b1;
        tick();
        bus.IREADY = 1'b0;
        settle();
        check("pop_count", dut.count_q, 2'd1);
        check("pop_ireq",  bus.IREQ,    1'b1);
        check("pop_instr", bus.INSTR,   32'h1111_1111);
        check("pop_ipc",   bus.IPC,     32'h4);
        $display("[TB] fill/drain heads 0,4");

        check("f2_iaddr", bus.IADDR, 32'h8);
        bus.IACK = 1'b1;
        tick();
        bus.PC    = 32'hC;
        bus.IACK  = 1'b0;
        bus.JMP   = 1'b1;
        bus.JADDR = 32'h100;
        settle();
        check("j1_en",   bus.EN,   1'b1);
        check("j1_nxpc", bus.NXPC, 32'h100);
        check("j1_ireq", bus.IREQ, 1'b0);
        tick();
        bus.JMP = 1'b0;
        bus.PC  = 32'h100;
        settle();
        check("j1_state",  dut.state_q, 2'd2);
        check("j1_count",  dut.count_q, 2'd0);
        check("j1_ivalid", bus.IVALID,  1'b0);
        check("j1_ireq",   bus.IREQ,    1'b0);
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'hDEAD_DEAD;
        tick();
        bus.IRVALID = 1'b0;
        settle();
        check("j1_drop_iv",   bus.IVALID, 1'b0);
        check("j1_ireq_back", bus.IREQ,   1'b1);
        check("j1_iaddr",     bus.IADDR,  32'h100);
        $display("[TB] redirect to 00000100, stale response dropped");

        bus.IACK = 1'b1;
        tick();
        bus.PC      = 32'h104;
        bus.IACK    = 1'b0;
        bus.JMP     = 1'b1;
        bus.JADDR   = 32'h200;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'hBEEF_BEEF;
        tick();
        bus.JMP     = 1'b0;
        bus.IRVALID = 1'b0;
        bus.PC      = 32'h200;
        settle();
        check("j2_state",  dut.state_q, 2'd0);
        check("j2_ivalid", bus.IVALID,  1'b0);
        check("j2_ireq",   bus.IREQ,    1'b1);
        $display("[TB] redirect with response, dropped");

        bus.IACK = 1'b1;
        tick();
        bus.PC      = 32'h204;
        bus.IACK    = 1'b0;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'hA0A0_A0A0;
        tick();
        bus.IRVALID = 1'b0;
        bus.IACK    = 1'b1;
        tick();
        bus.PC      = 32'h208;
        bus.IACK    = 1'b0;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'hA1A1_A1A1;
        bus.IREADY  = 1'b1;
        settle();
        check("pp_head_before", bus.IPC, 32'h200);
        tick();
        bus.IRVALID = 1'b0;
        bus.IREADY  = 1'b0;
        settle();
        check("pp_count", dut.count_q, 2'd1);
        check("pp_ipc",   bus.IPC,     32'h204);
        check("pp_instr", bus.INSTR,   32'hA1A1_A1A1);
        $display("[TB] push+pop at 00000204");

        bus.IREADY = 1'b1;
        bus.JMP    = 1'b1;
        bus.JADDR  = 32'h300;
        settle();
        check("j3_ireq", bus.IREQ, 1'b0);
        check("j3_nxpc", bus.NXPC, 32'h300);
        tick();
        bus.JMP    = 1'b0;
        bus.IREADY = 1'b0;
        bus.PC     = 32'h300;
        settle();
        check("j3_count",  dut.count_q, 2'd0);
        check("j3_ivalid", bus.IVALID,  1'b0);

        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'h5555_5555;
        tick();
        bus.IRVALID = 1'b0;
        settle();
        check("idle_rv_count", dut.count_q, 2'd0);
        check("idle_rv_state", dut.state_q, 2'd0);
        $display("[TB] idle response ignored");

        bus.PC   = 32'hFFFF_FFFC;
        bus.IACK = 1'b1;
        settle();
        check("wrap_en",   bus.EN,   1'b1);
        check("wrap_nxpc", bus.NXPC, 32'h0);
        tick();
        bus.PC      = 32'h0;
        bus.IACK    = 1'b0;
        bus.IRVALID = 1'b1;
        bus.IDATA   = 32'hC0C0_C0C0;
        tick();
        bus.IRVALID = 1'b0;
        bus.IACK    = 1'b1;
        settle();
        check("wrap_ipc", bus.IPC, 32'hFFFF_FFFC);
        tick();
        check("mid_state", dut.state_q, 2'd1);
        RES = 1'b0;
        settle();
        check("mid_ireq",   bus.IREQ,        1'b0);
        check("mid_ivalid", bus.IVALID,      1'b0);
        check("mid_en",     bus.EN,          1'b0);
        check("mid_pend",   dut.pend_addr_q, 32'h0000_0040);
        tick();
        tick();
        RES = 1'b1;
        settle();
        check("rel_state", dut.state_q, 2'd0);
        check("rel_ireq",  bus.IREQ,    1'b1);
        $display("[TB] wrap fetch and mid-transaction reset");

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
